add_accum: RTL and testbench

Operand accumulator that sits directly upstream of the result path and consumes the output of the team's `DATA_WIDTH`-bit ripple-carry adder.
- Accepts a stream of `DATA_WIDTH`-bit operands over a valid/ready handshake.
- Sums them into a running accumulator, with a sticky carry-out flag that marks overflow.
- On the operand marked `in_last`, presents the packet total, overflow flag and operand count on a second valid/ready handshake.
- Packets are summed one at a time; the block is a two-state controller around a single adder and an accumulator register.

---
 rtl/add_accum_if.sv | 28 ++
 rtl/add_accum.sv | 83 ++++++++
 tb/tb_add_accum.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/add_accum_if.sv
// add_accum_if: operand stream in, packet result out, both valid/ready.
//   in_valid/in_ready/in_data/in_last : operand stream (producer -> accumulator)
//   out_valid/out_ready/out_sum/out_carry/out_count : packet result (accumulator -> consumer)
// The master modport is the environment side; the slave modport is the accumulator.
interface add_accum_if #(
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned COUNT_WIDTH = 4
) ();
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_sum;
  logic                   out_carry;
  logic [COUNT_WIDTH-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_count
  );
endinterface

// File: rtl/add_accum.sv
// add_accum: sums a packet of operands into an accumulator and presents the total.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : add_accum_if.slave -- operand stream in, packet result out
// Two states: StAccum takes one operand per cycle; StHold presents sum, sticky carry
// and saturating count until the result handshake, then clears and resumes.
module add_accum #(
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned COUNT_WIDTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  add_accum_if.slave  bus
);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  acc_q, acc_d;
  logic                   ovf_q, ovf_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [DATA_WIDTH:0]    add_full;
  logic                   in_fire;
  logic                   out_fire;

  // Adder with cin = 0; top bit is the carry-out.
  assign add_full = {1'b0, acc_q} + {1'b0, bus.in_data};

  assign in_fire  = (state_q == StAccum) && bus.in_valid;
  assign out_fire = (state_q == StHold) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StAccum: begin
        if (in_fire) begin
          acc_d = add_full[DATA_WIDTH-1:0];
          ovf_d = ovf_q | add_full[DATA_WIDTH];
          // Count saturates at all-ones.
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + COUNT_WIDTH'(1);
          if (bus.in_last) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (out_fire) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAccum;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // in_ready depends only on state, so out_ready never reaches it combinationally.
  assign bus.in_ready  = (state_q == StAccum);
  assign bus.out_valid = (state_q == StHold);
  assign bus.out_sum   = acc_q;
  assign bus.out_carry = ovf_q;
  assign bus.out_count = cnt_q;

endmodule

// File: tb/tb_add_accum.sv
// tb_add_accum: directed packets against a packet-level model (integer running total,
// beat count, result pending flag), checked every falling edge, plus literal checks.
module tb_add_accum;
  localparam int DW   = 4;
  localparam int CW   = 4;
  localparam int MOD  = 1 << DW;
  localparam int CMAX = (1 << CW) - 1;

  logic clk;
  logic rst_n;

  add_accum_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

  add_accum #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end else begin
      passes++;
    end
  endtask

  // Packet-level model: total is the exact integer sum of the packet so far.
  int m_total;
  int m_n;
  bit m_hold;

  function automatic int m_sum();   return m_total % MOD; endfunction
  function automatic int m_carry(); return (m_total >= MOD) ? 1 : 0; endfunction
  function automatic int m_count(); return (m_n > CMAX) ? CMAX : m_n; endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_total <= 0;
      m_n     <= 0;
      m_hold  <= 1'b0;
    end else if (m_hold) begin
      if (bus.out_ready) begin
        m_total <= 0;
        m_n     <= 0;
        m_hold  <= 1'b0;
      end
    end else if (bus.in_valid) begin
      m_total <= m_total + int'(bus.in_data);
      m_n     <= m_n + 1;
      if (bus.in_last) m_hold <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("in_ready", 32'(bus.in_ready), 32'(!m_hold));
      chk("out_valid", 32'(bus.out_valid), 32'(m_hold));
      if (m_hold) begin
        chk("out_sum", 32'(bus.out_sum), 32'(m_sum()));
        chk("out_carry", 32'(bus.out_carry), 32'(m_carry()));
        chk("out_count", 32'(bus.out_count), 32'(m_count()));
      end
    end
  end

  // Drive one beat; time is left at posedge+1.
  task automatic send(input int d, input bit last);
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(d);
    bus.in_last  = last;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Called at posedge+1 right after the last beat: pin values, then hand the result off.
  task automatic take(input string name, input int s, input int c, input int n);
    chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, "_sum"}, 32'(bus.out_sum), 32'(s));
    chk({name, "_carry"}, 32'(bus.out_carry), 32'(c));
    chk({name, "_count"}, 32'(bus.out_count), 32'(n));
    chk({name, "_model_sum"}, 32'(m_sum()), 32'(s));
    chk({name, "_model_count"}, 32'(m_count()), 32'(n));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({name, "_after_ready"}, 32'(bus.in_ready), 32'd1);
    chk({name, "_after_sum"}, 32'(bus.out_sum), 32'd0);
    chk({name, "_after_count"}, 32'(bus.out_count), 32'd0);
  endtask

  // Asynchronous reset pulse mid-cycle; outputs must clear before any clock edge.
  task automatic reset_pulse(input string name);
    #2 rst_n = 1'b0;
    #1;
    chk({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({name, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({name, "_out_sum"}, 32'(bus.out_sum), 32'd0);
    chk({name, "_out_carry"}, 32'(bus.out_carry), 32'd0);
    chk({name, "_out_count"}, 32'(bus.out_count), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic packet.
    send(3, 0); send(5, 0); send(7, 1);
    take("basic", 15, 0, 3);

    // Sticky overflow: 9+8 carries, +1 does not.
    send(9, 0); send(8, 0); send(1, 1);
    take("ovf", 2, 1, 3);

    // Backpressure with a pending operand that must wait.
    send(6, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(4);
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_sum", 32'(bus.out_sum), 32'd6);
      chk("bp_count", 32'(bus.out_count), 32'd1);
      @(posedge clk); #1;
    end
    take("bp", 6, 0, 1);
    // The held operand is accepted on the first edge back in accumulate.
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    take("bp_next", 4, 0, 1);

    // Count saturation with gaps.
    for (int i = 0; i < 20; i++) begin
      send(0, (i == 19));
      if (i != 19) idle(1);
    end
    take("sat", 0, 0, CMAX);

    // Reset mid-packet, then a one-beat packet right after release.
    send(7, 0); send(7, 0);
    reset_pulse("rst_mid");
    send(2, 1);
    take("after_rst", 2, 0, 1);

    // Reset while holding a result.
    send(5, 1);
    reset_pulse("rst_hold");
    send(1, 1);
    take("after_rst_hold", 1, 0, 1);

    idle(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got 0 expected 1");
    $fatal(1);
  end
endmodule
